// File: rtl/stream_tg_pkg.sv
// Shared types for the stream traffic generator: source FSM states and the
// duty-cycle throttle configuration.
package stream_tg_pkg;

    // Internal throttle width; narrower period/on fields are zero-extended.
    localparam int THR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } src_state_e;

    typedef struct packed {
        logic [THR_W-1:0] on;
        logic [THR_W-1:0] period;
    } thr_cfg_t;

endpackage

// File: rtl/stream_traffic_gen_duty_throttle.sv
// Duty-cycle window: a phase counter wrapping at the period, and a compare
// against the on-count. The window is reported for the *next* cycle so that
// a registered valid/ready lands exactly in the open phases.
import stream_tg_pkg::*;

module duty_throttle (
    input  logic     clk,
    input  logic     reset,
    input  logic     run,
    input  logic     clr,
    input  thr_cfg_t cfg,
    output logic     win_nxt
);

    logic [THR_W-1:0] phase;
    logic [THR_W-1:0] phase_nxt;
    logic [THR_W-1:0] period_eff;

    // Next phase: clear wins, otherwise count and wrap; a zero period acts as 1.
    always_comb begin
        period_eff = (cfg.period == '0) ? THR_W'(1) : cfg.period;
        phase_nxt  = phase;
        if (clr)
            phase_nxt = '0;
        else if (run)
            phase_nxt = (phase >= period_eff - THR_W'(1)) ? '0 : phase + THR_W'(1);
        win_nxt = (phase_nxt < cfg.on);
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (!reset)
            phase <= '0;
        else
            phase <= phase_nxt;
    end

endmodule

// File: rtl/stream_traffic_gen.sv
// Stream source/sink pair for bring-up: the source replays a pattern RAM as a
// throttled valid/ready stream, the sink applies a ready pattern and gathers
// beat, frame and checksum statistics.
import stream_tg_pkg::*;

module stream_traffic_gen #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4096,
    parameter  int CNT_W  = 32,
    parameter  int PER_W  = 10,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_loop,
    input  logic [CNT_W-1:0]  cfg_last_every,
    input  logic [PER_W-1:0]  cfg_src_on,
    input  logic [PER_W-1:0]  cfg_src_period,
    input  logic [PER_W-1:0]  cfg_snk_on,
    input  logic [PER_W-1:0]  cfg_snk_period,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    output logic              m_last,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              pass_done,
    output logic [CNT_W-1:0]  src_beats,
    output logic [CNT_W-1:0]  snk_beats,
    output logic [CNT_W-1:0]  snk_frames,
    output logic [31:0]       snk_sum
);

    src_state_e        state, state_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  len_q, last_every_q, load_idx, last_cnt;
    logic              loop_q, m_fin;
    thr_cfg_t          src_cfg_q, snk_cfg;
    logic              src_win, snk_win;
    logic              fire, load, pass_end, is_fin, hit, snk_fire;
    logic              unused_snk_hi;

    assign fire     = m_valid & m_ready;
    assign snk_fire = s_valid & s_ready;
    assign is_fin   = (load_idx == len_q - CNT_W'(1));
    assign hit      = (last_every_q != '0) && (last_cnt + CNT_W'(1) == last_every_q);
    assign snk_cfg  = '{on: THR_W'(cfg_snk_on), period: THR_W'(cfg_snk_period)};
    // Only the low word feeds the checksum.
    assign unused_snk_hi = ^s_data;

    // Source window counts only while streaming; sink window free-runs.
    duty_throttle u_src_thr (
        .clk     (clk),
        .reset   (reset),
        .run     (state == STREAM),
        .clr     (state != STREAM),
        .cfg     (src_cfg_q),
        .win_nxt (src_win)
    );

    duty_throttle u_snk_thr (
        .clk     (clk),
        .reset   (reset),
        .run     (1'b1),
        .clr     (1'b0),
        .cfg     (snk_cfg),
        .win_nxt (snk_win)
    );

    // Pattern RAM: read address is the combinational next address, so the
    // word for the next beat is ready one cycle after a fire; same-address
    // write returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr_nxt];
    end

    // Source next-state, beat load decision and read-address advance.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        load        = 1'b0;
        pass_end    = 1'b0;
        if (start) begin
            state_nxt   = FETCH;
            rd_addr_nxt = '0;
        end else begin
            case (state)
                FETCH: begin
                    // RAM word 0 is already in rd_q; present it on entering STREAM.
                    state_nxt = STREAM;
                    load      = src_win;
                end
                STREAM: begin
                    if (fire && m_fin) begin
                        pass_end    = 1'b1;
                        state_nxt   = loop_q ? FETCH : IDLE;
                        rd_addr_nxt = '0;
                    end else begin
                        load = (!m_valid || fire) && (load_idx < len_q) && src_win;
                    end
                end
                default: ;
            endcase
            if (load)
                rd_addr_nxt = rd_addr + ADDR_W'(1);
        end
    end

    // Source state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Source datapath: config latch, held beat registers, pass bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_addr      <= '0;
            len_q        <= CNT_W'(1);
            last_every_q <= '0;
            loop_q       <= 1'b0;
            src_cfg_q    <= '{on: THR_W'(1), period: THR_W'(1)};
            load_idx     <= '0;
            last_cnt     <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_data       <= '0;
            m_fin        <= 1'b0;
            src_beats    <= '0;
            pass_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rd_addr   <= rd_addr_nxt;
            pass_done <= pass_end;
            busy      <= (state_nxt != IDLE) || pass_end;
            if (start) begin
                // Abort: any held beat is dropped and statistics restart.
                len_q        <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                last_every_q <= cfg_last_every;
                loop_q       <= cfg_loop;
                src_cfg_q    <= '{on: THR_W'(cfg_src_on), period: THR_W'(cfg_src_period)};
                load_idx     <= '0;
                last_cnt     <= '0;
                m_valid      <= 1'b0;
                m_last       <= 1'b0;
                m_fin        <= 1'b0;
                src_beats    <= '0;
            end else begin
                if (fire && src_beats != '1)
                    src_beats <= src_beats + CNT_W'(1);
                if (load) begin
                    m_valid  <= 1'b1;
                    m_data   <= rd_q;
                    m_last   <= hit || is_fin;
                    m_fin    <= is_fin;
                    load_idx <= load_idx + CNT_W'(1);
                    last_cnt <= hit ? '0 : last_cnt + CNT_W'(1);
                end else if (fire) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
                if (pass_end) begin
                    load_idx <= '0;
                    last_cnt <= '0;
                    m_fin    <= 1'b0;
                end
            end
        end
    end

    // Sink: registered ready pattern and statistics; start clears, then
    // a coincident beat still counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_ready    <= 1'b0;
            snk_beats  <= '0;
            snk_frames <= '0;
            snk_sum    <= '0;
        end else begin
            s_ready <= snk_win;
            if (start) begin
                snk_beats  <= CNT_W'(snk_fire);
                snk_frames <= CNT_W'(snk_fire && s_last);
                snk_sum    <= snk_fire ? s_data[31:0] : 32'd0;
            end else if (snk_fire) begin
                if (snk_beats != '1)
                    snk_beats <= snk_beats + CNT_W'(1);
                if (s_last && snk_frames != '1)
                    snk_frames <= snk_frames + CNT_W'(1);
                snk_sum <= snk_sum + s_data[31:0];
            end
        end
    end

endmodule

// File: tb/tb_stream_traffic_gen.sv
// Directed bench for stream_traffic_gen: source looped back into the sink
// through a bench-controlled gate, table of single-pass vectors plus
// hand-written loop / reset / abort sequences.
module tb_stream_traffic_gen;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 32;
    localparam int PER_W  = 10;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk, reset, start, cfg_loop, wr_en, gate;
    logic [CNT_W-1:0]  cfg_len, cfg_last_every;
    logic [PER_W-1:0]  cfg_src_on, cfg_src_period, cfg_snk_on, cfg_snk_period;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, m_data, s_data;
    logic              m_valid, m_last, m_ready, s_valid, s_last, s_ready;
    logic              busy, pass_done;
    logic [CNT_W-1:0]  src_beats, snk_beats, snk_frames;
    logic [31:0]       snk_sum;

    assign s_valid = m_valid & gate;
    assign s_last  = m_last;
    assign s_data  = m_data;
    assign m_ready = s_ready & gate;

    stream_traffic_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .cfg_last_every(cfg_last_every), .cfg_src_on(cfg_src_on), .cfg_src_period(cfg_src_period),
        .cfg_snk_on(cfg_snk_on), .cfg_snk_period(cfg_snk_period), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .m_valid(m_valid), .m_last(m_last),
        .m_data(m_data), .m_ready(m_ready), .s_valid(s_valid), .s_last(s_last),
        .s_data(s_data), .s_ready(s_ready), .busy(busy), .pass_done(pass_done),
        .src_beats(src_beats), .snk_beats(snk_beats), .snk_frames(snk_frames), .snk_sum(snk_sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every handshake, count pass_done pulses, watch hold rule.
    logic [63:0] fire_dat [$];
    logic        fire_lst [$];
    int          fire_cyc [$];
    int          pass_cnt = 0;
    int          hold_err = 0;
    logic        hold_chk = 1'b0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [63:0] pd = '0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            fire_dat.push_back(m_data);
            fire_lst.push_back(m_last);
            fire_cyc.push_back(cyc);
        end
        if (pass_done) pass_cnt++;
        if (hold_chk && pv && !pr && (!m_valid || m_data != pd || m_last != pl)) hold_err++;
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass_done"}, pass_done, 0);
        chk({tag, "_counters"}, {src_beats | snk_beats | snk_frames, snk_sum}, 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 2000 && busy; k++) step();
        chk({tag, "_idle_timeout"}, busy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_cfg(input int len, input int lp, input int every,
                           input int son, input int sper, input int kon, input int kper);
        cfg_len        = CNT_W'(len);
        cfg_loop       = lp[0];
        cfg_last_every = CNT_W'(every);
        cfg_src_on     = PER_W'(son);
        cfg_src_period = PER_W'(sper);
        cfg_snk_on     = PER_W'(kon);
        cfg_snk_period = PER_W'(kper);
    endtask

    // Checks logged beats from index fb: data i, m_last per the period rule.
    task automatic chk_stream(input string tag, input int fb, input int n, input int le, input int every);
        int bad = 0;
        logic el;
        for (int i = 0; i < n; i++) begin
            el = ((every != 0) && ((i + 1) % every == 0)) || (i == le - 1);
            if (fire_dat[fb + i] != 64'(i) || fire_lst[fb + i] != el) bad++;
        end
        chk({tag, "_stream_order"}, bad, 0);
    endtask

    typedef struct {
        int len, every, src_on, src_per, snk_on, snk_per;
        int exp_beats, exp_frames, exp_sum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int fb, pb, hb, n, le, bad, k;

        vecs[0] = '{len: 8,  every: 0, src_on: 1, src_per: 1, snk_on: 1, snk_per: 1, exp_beats: 8,  exp_frames: 1, exp_sum: 28};
        vecs[1] = '{len: 16, every: 4, src_on: 2, src_per: 5, snk_on: 1, snk_per: 1, exp_beats: 16, exp_frames: 4, exp_sum: 120};
        vecs[2] = '{len: 10, every: 0, src_on: 1, src_per: 1, snk_on: 1, snk_per: 3, exp_beats: 10, exp_frames: 1, exp_sum: 45};
        vecs[3] = '{len: 0,  every: 0, src_on: 1, src_per: 1, snk_on: 1, snk_per: 1, exp_beats: 1,  exp_frames: 1, exp_sum: 0};
        vecs[4] = '{len: 5,  every: 2, src_on: 3, src_per: 2, snk_on: 2, snk_per: 4, exp_beats: 5,  exp_frames: 3, exp_sum: 10};

        reset = 1'b0; start = 1'b0; gate = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_cfg(1, 0, 0, 1, 1, 1, 1);
        repeat (3) step();
        chk_reset_vals("por");

        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
            step();
        end
        wr_en = 1'b0;
        step();

        // Table-driven single passes.
        foreach (vecs[v]) begin
            set_cfg(vecs[v].len, 0, vecs[v].every, vecs[v].src_on, vecs[v].src_per,
                    vecs[v].snk_on, vecs[v].snk_per);
            step();
            fb = fire_dat.size(); pb = pass_cnt; hb = hold_err;
            hold_chk = 1'b1;
            pulse_start();
            chk($sformatf("v%0d_fetch_no_valid", v), m_valid, 0);
            chk($sformatf("v%0d_busy_rise", v), busy, 1);
            step();
            chk($sformatf("v%0d_first_valid", v), m_valid, 1);
            chk($sformatf("v%0d_first_data", v), m_data, 0);
            wait_idle($sformatf("v%0d", v));
            step(); step();
            hold_chk = 1'b0;
            n  = fire_dat.size() - fb;
            le = (vecs[v].len == 0) ? 1 : vecs[v].len;
            chk($sformatf("v%0d_fire_count", v), n, vecs[v].exp_beats);
            chk($sformatf("v%0d_src_beats", v), src_beats, vecs[v].exp_beats);
            chk($sformatf("v%0d_snk_beats", v), snk_beats, vecs[v].exp_beats);
            chk($sformatf("v%0d_snk_frames", v), snk_frames, vecs[v].exp_frames);
            chk($sformatf("v%0d_snk_sum", v), snk_sum, vecs[v].exp_sum);
            chk($sformatf("v%0d_pass_done", v), pass_cnt - pb, 1);
            chk($sformatf("v%0d_hold", v), hold_err - hb, 0);
            if (n == le) begin
                chk_stream($sformatf("v%0d", v), fb, n, le, vecs[v].every);
                if (vecs[v].snk_on >= vecs[v].snk_per) begin
                    bad = 0;
                    for (int i = 0; i < n; i++) begin
                        k = fire_cyc[fb + i] - fire_cyc[fb];
                        if (vecs[v].src_on < vecs[v].src_per) begin
                            if (k % vecs[v].src_per >= vecs[v].src_on) bad++;
                        end else if (k != i) bad++;
                    end
                    chk($sformatf("v%0d_beat_timing", v), bad, 0);
                end
            end
        end

        // Loop mode: three passes of four, one bubble between passes.
        set_cfg(4, 1, 0, 1, 1, 1, 1);
        step();
        fb = fire_dat.size(); pb = pass_cnt;
        pulse_start();
        for (int i = 0; i < 500 && (pass_cnt - pb) < 3; i++) step();
        chk("loop_pass_count", pass_cnt - pb, 3);
        chk("loop_src_beats", src_beats, 12);
        chk("loop_busy", busy, 1);
        if (fire_dat.size() - fb >= 12) begin
            bad = 0;
            for (int i = 0; i < 12; i++) begin
                if (fire_cyc[fb + i] - fire_cyc[fb] != i + i / 4) bad++;
                if (fire_dat[fb + i] != 64'(i % 4) || fire_lst[fb + i] != (i % 4 == 3)) bad++;
            end
            chk("loop_bubble_and_data", bad, 0);
        end else begin
            chk("loop_fire_count", fire_dat.size() - fb, 12);
        end

        // Reset while beat 3 of the fourth pass is presented.
        for (k = 0; k < 50 && !(m_valid && m_data == 64'd3); k++) step();
        chk("reset_reach_beat3", m_valid && m_data == 64'd3, 1);
        reset = 1'b0;
        step();
        chk_reset_vals("midrst");
        reset = 1'b1;
        set_cfg(8, 0, 0, 1, 1, 1, 1);
        step();
        fb = fire_dat.size();
        pulse_start();
        wait_idle("replay");
        step();
        chk("replay_count", fire_dat.size() - fb, 8);
        if (fire_dat.size() - fb == 8) chk_stream("replay", fb, 8, 8, 0);
        chk("replay_sum", snk_sum, 28);

        // Abort at beat 5 of 10 while that beat is held; it is dropped.
        set_cfg(10, 0, 0, 1, 1, 1, 1);
        step();
        pulse_start();
        for (k = 0; k < 50 && !(m_valid && m_data == 64'd4); k++) step();
        step();
        chk("abort_beat5_shown", m_data, 5);
        gate = 1'b0;
        pulse_start();
        gate = 1'b1;
        chk("abort_drop_valid", m_valid, 0);
        chk("abort_clear", {src_beats, snk_beats}, 0);
        fb = fire_dat.size();
        wait_idle("abort");
        step();
        chk("abort_src_beats", src_beats, 10);
        chk("abort_snk_beats", snk_beats, 10);
        chk("abort_snk_sum", snk_sum, 45);
        chk("abort_frames", snk_frames, 1);
        chk("abort_count", fire_dat.size() - fb, 10);
        if (fire_dat.size() - fb == 10) chk_stream("abort", fb, 10, 10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_traffic_gen.md
# stream_traffic_gen

Synthesizable, parametrised stream source/sink pair for bench and on-board bring-up of the systolic datapath (Img2Col stream, weight cache). The source replays a preloaded pattern RAM as a valid/ready stream. It supports programmable length, duty-cycle throttling, periodic `last` and loop/restart. The sink applies a programmable ready pattern and accumulates beat, frame and checksum statistics, so throughput and correctness are measurable without file I/O.

## Interface
- `DATA_W`, 64, stream and RAM word width (multiple of 32)
- `DEPTH`, 4096, pattern RAM words; `ADDR_W = $clog2(DEPTH)`
- `CNT_W`, 32, width of length/statistic counters
- `PER_W`, 10, width of throttle period/on fields

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse: clear statistics, begin a run
- `cfg_len`  in  CNT_W  beats per pass (1..DEPTH; 0 treated as 1)
- `cfg_loop`  in  1  1: restart from address 0 after each pass
- `cfg_last_every`  in  CNT_W  `m_last` period in beats (0 = only final beat)
- `cfg_src_on` / `cfg_src_period`  in  PER_W each  source valid window
- `cfg_snk_on` / `cfg_snk_period`  in  PER_W each  sink ready window
- `wr_en`, `wr_addr[ADDR_W]`, `wr_data[DATA_W]`  in  pattern RAM load port
- `m_valid`/`m_last` out 1, `m_data` out DATA_W, `m_ready` in 1  source stream
- `s_valid`/`s_last` in 1, `s_data` in DATA_W, `s_ready` out 1  sink stream
- `busy`  out 1; `pass_done`  out 1  one-cycle pulse per completed pass
- `src_beats`, `snk_beats`, `snk_frames`  out CNT_W; `snk_sum`  out 32

## Operation
- Source FSM: IDLE → FETCH → STREAM → IDLE.
  - IDLE: on `start`, latch cfg, rd_addr=0, go to FETCH.
  - FETCH: one cycle for the RAM read latency, then STREAM.
  - STREAM: present beats at `beat_idx`.
- Fire = `m_valid & m_ready`. On fire, rd_addr advances combinationally, so the next word is on `m_data` the following cycle. Zero-bubble streaming at 100 % duty.
- Throttle: `src_phase` counts 0..cfg_src_period-1 and wraps while in STREAM. A new beat may raise `m_valid` only when `src_phase < cfg_src_on`. Once raised, `m_valid`, `m_data` and `m_last` hold until fire. `cfg_src_on ≥ cfg_src_period` means always on. A period of 0 is treated as 1.
- `m_last` = 1 when `(beat_idx+1) % cfg_last_every == 0` or `beat_idx == cfg_len-1`.
- End of pass (fire on beat cfg_len-1): pulse `pass_done`.
  - `cfg_loop=0`: go to IDLE.
  - `cfg_loop=1`: beat_idx=0, rd_addr=0, go through FETCH again (one bubble), and continue until a new `start`.
- `start` in any state aborts the current pass and restarts from FETCH. It is legal even while `m_valid` is held; that beat is dropped.
- Sink: `snk_phase` runs the same throttle scheme on `s_ready`, always running after reset. On `s_valid & s_ready`: `snk_beats`+1, `snk_sum += s_data[31:0]` (mod 2^32), and `snk_frames`+1 if `s_last`.
- `start` clears `src_beats`, `snk_beats`, `snk_frames`, `snk_sum`. If `start` and a sink beat coincide, the result is 1 beat (clear, then count).
- RAM writes are allowed at any time. A write to the address being read in the same cycle returns the old data.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `m_data=0`, `s_ready=0`, `busy=0`, `pass_done=0`, all counters 0, FSM IDLE, both phases 0.
- Latency: `start` at cycle T → `m_valid` no earlier than T+2 (FETCH at T+1).
- `busy` = 1 from T+1 until the cycle after the final fire.
- `pass_done` is asserted in the cycle after the final fire.
- `s_ready` is a registered output of phase only; no combinational path from `s_valid`.
- `m_valid` has no combinational path from `m_ready`.
- A `reset` asserted mid-run returns everything to reset values at the next edge; RAM contents are retained.

## Structure
- Shared package `stream_tg_pkg`: FSM state enum (IDLE/FETCH/STREAM) and a throttle-config struct {on, period}.
- One natural sub-module: `duty_throttle` (phase counter + window compare), instantiated for source and sink.
- Pattern RAM is an inferred simple-dual-port array inside the top.

## Test plan
- Load RAM[i]=i, len=8, loop=0, on=period=1, sink always ready → 8 beats 0..7 back-to-back, `m_last` on beat 7 only, `pass_done` once, snk_sum=28.
- len=16, last_every=4, src on=2/period=5 → `m_valid` only in phases 0–1; `m_last` on beats 3, 7, 11, 15; snk_frames=4.
- Sink on=1/period=3 with source always on → `m_valid` held stable with unchanged `m_data` across stalls; snk_beats=len; no beat lost or duplicated.
- loop=1, len=4 for 3 passes → 3 `pass_done` pulses, one FETCH bubble between passes, src_beats=12.
- `start` mid-pass at beat 5 of 10 → counters clear, stream restarts at data 0, beat 5 is dropped, final src_beats=10.
- `reset` low at beat 3 → all outputs at reset values next cycle; a subsequent `start` replays the retained RAM contents.
